// File: rtl/tile_rom_arbiter.sv
// tile_rom_arbiter: two-port tile ROM arbiter with a starvation guard for port 1 and a tagged read-return pipeline.
// Define TILE_ROM_ARBITER_RR_EN to replace the starvation FSM with round-robin arbitration.
module tile_rom_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 24,
  parameter int ROM_LAT    = 2,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              valid0,
  output logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              valid1,
  output logic [DATA_W-1:0] data1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT-1:0] tv_q, tv_d, tid_q, tid_d;
  logic valid0_q, valid0_d, valid1_q, valid1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
`ifdef TILE_ROM_ARBITER_RR_EN
  logic last_q, last_d;
`else
  typedef enum logic {NORMAL, FORCE1} state_t;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
`endif
  always_comb begin
`ifdef TILE_ROM_ARBITER_RR_EN
    gnt0 = rst_n & req0 & (~req1 | last_q);
    gnt1 = rst_n & req1 & (~req0 | ~last_q);
    last_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
`else
    gnt0 = rst_n & req0 & ((state_q == NORMAL) | ~req1);
    gnt1 = rst_n & req1 & ((state_q == FORCE1) | ~req0);
    cnt_d = (~req1 | gnt1) ? 8'd0 : (cnt_q == SMAX) ? cnt_q : cnt_q + 8'd1;
    // Enter FORCE1 as soon as this cycle's denial completes the starvation run
    state_d = (state_q == NORMAL && req1 && cnt_d == SMAX) ? FORCE1 : NORMAL;
`endif
    rom_address = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
    addr_d = rom_address;
    tv_d = (tv_q << 1) | ROM_LAT'(gnt0 | gnt1);
    tid_d = (tid_q << 1) | ROM_LAT'(gnt1);
    valid0_d = tv_q[ROM_LAT-1] & ~tid_q[ROM_LAT-1];
    valid1_d = tv_q[ROM_LAT-1] & tid_q[ROM_LAT-1];
    data0_d = valid0_d ? rom_q : data0_q;
    data1_d = valid1_d ? rom_q : data1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      tv_q     <= '0;
      tid_q    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
`ifdef TILE_ROM_ARBITER_RR_EN
      last_q   <= 1'b1;
`else
      state_q  <= NORMAL;
      cnt_q    <= 8'd0;
`endif
    end else begin
      addr_q   <= addr_d;
      tv_q     <= tv_d;
      tid_q    <= tid_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
`ifdef TILE_ROM_ARBITER_RR_EN
      last_q   <= last_d;
`else
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;
  assign data0 = data0_q;
  assign data1 = data1_q;
endmodule

// File: tb/tb_tile_rom_arbiter.sv
// tb_tile_rom_arbiter: randomized and directed checks of tile_rom_arbiter against a cycle-level policy model.
module tb_tile_rom_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 7;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, rom_address;
  logic gnt0, gnt1, valid0, valid1;
  logic [23:0] data0, data1, rom_q;
  logic [7:0] rp [LAT] = '{default: 8'd0};
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {int due; bit port; logic [7:0] addr;} resp_t;
  resp_t q[$];
  int denied;
  bit last1;
  logic [7:0] last_addr;
  logic [23:0] ld0, ld1;
  logic e_g0, e_g1, e_v0, e_v1;
  logic [59:0] got, exp;

  tile_rom_arbiter #(.ADDR_W(8), .DATA_W(24), .ROM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .valid0(valid0), .data0(data0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .valid1(valid1), .data1(data1),
    .rom_address(rom_address), .rom_q(rom_q)
  );

  function automatic logic [23:0] rom_f(input logic [7:0] a);
    return {a ^ 8'h3C, ~a, a + 8'd7};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rp[0] <= rom_address;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign rom_q = rom_f(rp[LAT-1]);
  assign got = {gnt0, gnt1, rom_address, valid0, valid1, data0, data1};

  task automatic model_clear();
    q.delete();
    denied = 0;
    last1 = 1'b1;
    last_addr = 8'd0;
    ld0 = '0;
    ld1 = '0;
  endtask

  // One cycle: drive inputs mid-cycle, then predict every output for this cycle
  task automatic tick(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
    @(negedge clk);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
`ifdef TILE_ROM_ARBITER_RR_EN
    e_g0 = r0 && (!r1 || last1);
    e_g1 = r1 && !e_g0;
    if (e_g0 || e_g1) last1 = e_g1;
`else
    e_g1 = r1 && (denied == SMAX || !r0);
    e_g0 = r0 && !e_g1;
    denied = (r1 && !e_g1) ? denied + 1 : 0;
`endif
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].port) begin e_v1 = 1'b1; ld1 = rom_f(q[0].addr); end
      else begin e_v0 = 1'b1; ld0 = rom_f(q[0].addr); end
      void'(q.pop_front());
    end
    if (e_g0 || e_g1) begin
      last_addr = e_g0 ? a0 : a1;
      q.push_back('{cyc + LAT + 1, e_g1, last_addr});
    end
    exp = {e_g0, e_g1, last_addr, e_v0, e_v1, ld0, ld1};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #2;
    if (got !== 60'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", got); end
    checks++;
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h11; addr1 = 8'h22;
    #1;
    if (got !== 60'd0) begin errors++; $display("FAIL reset_gnt_gated got=%h exp=0", got); end
    checks++;
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    model_clear();
  endtask

  task automatic test_seq_port0();
    int n0 = 0, n1 = 0, c0 = 0, fv = -1;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) tick(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
      else tick(1'b0, 8'h00, 1'b0, 8'h00);
      if (i == 0) c0 = cyc;
      if (valid0 === 1'b1) begin n0++; if (fv < 0) fv = cyc; end
      if (valid1 === 1'b1) n1++;
      if (got !== exp) begin errors++; $display("FAIL seq_port0 cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
    end
    if (n0 !== 16) begin errors++; $display("FAIL seq_valid0_count got=%0d exp=16", n0); end
    checks++;
    if (n1 !== 0) begin errors++; $display("FAIL seq_valid1_count got=%0d exp=0", n1); end
    checks++;
    if (fv - c0 !== LAT + 1) begin errors++; $display("FAIL seq_latency got=%0d exp=%0d", fv - c0, LAT + 1); end
    checks++;
  endtask

  task automatic test_port1();
    tick(1'b0, 8'h00, 1'b1, 8'hA5);
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || rom_address !== 8'hA5) begin
      errors++; $display("FAIL port1_grant got=%b%b/%h exp=01/a5", gnt0, gnt1, rom_address);
    end
    checks++;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      if (got !== exp) begin errors++; $display("FAIL port1_model cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
      if (k == LAT + 1 && (valid1 !== 1'b1 || data1 !== rom_f(8'hA5))) begin
        errors++; $display("FAIL port1_data got=%b/%h exp=1/%h", valid1, data1, rom_f(8'hA5));
      end
      if (k == LAT + 1) checks++;
      if (k == LAT + 2 && (valid1 !== 1'b0 || data1 !== rom_f(8'hA5))) begin
        errors++; $display("FAIL port1_hold got=%b/%h exp=0/%h", valid1, data1, rom_f(8'hA5));
      end
      if (k == LAT + 2) checks++;
    end
  endtask

  task automatic test_starve();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 8'h30, 1'b1, 8'hC0);
      if (got !== exp) begin errors++; $display("FAIL starve_model cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
`ifdef TILE_ROM_ARBITER_RR_EN
      if (gnt1 !== (i % 2 == 1)) begin errors++; $display("FAIL rr_pattern i=%0d got=%b exp=%b", i, gnt1, i % 2 == 1); end
`else
      if (gnt1 !== (i % 8 == 7)) begin errors++; $display("FAIL starve_pattern i=%0d got=%b exp=%b", i, gnt1, i % 8 == 7); end
`endif
      checks++;
    end
  endtask

  task automatic test_force_drop();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 8'h50, (i != 7), 8'hD0);
      if (got !== exp) begin errors++; $display("FAIL force_drop_model cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
`ifndef TILE_ROM_ARBITER_RR_EN
      if (i >= 7 && (gnt0 !== 1'b1 || gnt1 !== 1'b0)) begin
        errors++; $display("FAIL force_drop_grant i=%0d got=%b%b exp=10", i, gnt0, gnt1);
      end
      if (i >= 7) checks++;
`endif
    end
  endtask

  task automatic test_reset_inflight();
    int nv = 0;
    tick(1'b1, 8'h40, 1'b0, 8'h00);
    tick(1'b0, 8'h00, 1'b1, 8'h41);
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    if (got !== 60'd0) begin errors++; $display("FAIL inflight_reset_assert got=%h exp=0", got); end
    checks++;
    @(negedge clk);
    #1;
    if (got !== 60'd0) begin errors++; $display("FAIL inflight_reset_hold got=%h exp=0", got); end
    checks++;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      if (valid0 === 1'b1 || valid1 === 1'b1) nv++;
      if (got !== exp) begin errors++; $display("FAIL inflight_model cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
    end
    if (nv !== 0) begin errors++; $display("FAIL inflight_discard got=%0d exp=0", nv); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'h60, 1'b1, 8'hE0);
      if (got !== exp) begin errors++; $display("FAIL inflight_restart cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
    end
  endtask

  task automatic test_random();
    logic p0 = 1'b0, p1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1'b1; a0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1'b1; a1 = 8'($urandom); end
      tick(p0, a0, p1, a1);
      if (got !== exp) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
      if (e_g0) p0 = 1'b0;
      if (e_g1) p1 = 1'b0;
    end
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      if (got !== exp) begin errors++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, got, exp); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_seq_port0();
    test_port1();
    test_starve();
    test_force_drop();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_rom_arbiter.md
TILE_ROM_ARBITER -- requirements
Module: tile_rom_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8: tile ROM address width.
REQ-002 The module SHALL have parameter DATA_W, default 24: tile ROM data width (RGB888).
REQ-003 The module SHALL have parameter ROM_LAT, default 2: cycles from rom_address to valid rom_q, range 1..4.
REQ-004 The module SHALL have parameter STARVE_MAX, default 7: consecutive denied cycles of port 1 before a forced grant, range 1..255.
REQ-005 The module SHALL have port clk, input, 1 bit: pixel-domain clock shared with the tile ROM; all logic on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port req0, input, 1 bit: port 0 (background layer) read request.
REQ-008 The module SHALL have port addr0, input, ADDR_W: port 0 read address.
REQ-009 The module SHALL have port gnt0, output, 1 bit: port 0 address accepted this cycle.
REQ-010 The module SHALL have port valid0, output, 1 bit: data0 holds port 0 read data.
REQ-011 The module SHALL have port data0, output, DATA_W: port 0 read data.
REQ-012 The module SHALL have ports req1, addr1, gnt1, valid1, data1, with the same widths and meanings as port 0, for port 1 (sprite layer: paddles, ball).
REQ-013 The module SHALL have port rom_address, output, ADDR_W: address to the tile ROM.
REQ-014 The module SHALL have port rom_q, input, DATA_W: tile ROM read data.

Function
REQ-015 The arbiter SHALL grant at most one port per cycle; gntN is combinational from reqN and state, and the address is accepted in the cycle gntN=1.
REQ-016 rom_address SHALL equal the granted port's address in the grant cycle and SHALL hold its previous value in cycles with no grant.
REQ-017 The FSM SHALL have states NORMAL and FORCE1. In NORMAL, port 0 has fixed priority. In FORCE1, port 1 is granted if req1=1, and port 0 is denied.
REQ-018 Starvation counter (8 bits): increments in cycles with req1=1 and gnt1=0, clears on any gnt1=1 or req1=0, and saturates at STARVE_MAX.
REQ-019 NORMAL -> FORCE1 SHALL occur when the counter equals STARVE_MAX and req1=1. FORCE1 -> NORMAL SHALL occur after exactly one cycle, unconditionally, and the counter clears.
REQ-020 If req1 drops while in FORCE1, that cycle SHALL grant port 0 if req0=1, and the FSM returns to NORMAL.
REQ-021 A ROM_LAT-deep tag pipeline SHALL carry {valid, port id} of each grant alongside the ROM read.
REQ-022 dataN/validN SHALL be registered; validN=1 exactly ROM_LAT+1 cycles after the gntN cycle, with dataN = rom_q for that read.
REQ-023 Back-to-back grants SHALL sustain one read per cycle with no bubbles; response order equals grant order.
REQ-024 dataN SHALL hold its last value when validN=0.
REQ-025 Requests SHALL have no queueing: a denied request is simply not granted, and the requester holds reqN/addrN until granted.

Reset
REQ-026 While rst_n=0: state=NORMAL, counter=0, tag pipeline cleared, gnt0=gnt1=0, valid0=valid1=0, data0=data1=0, rom_address=0.
REQ-027 Reads in flight at reset assertion SHALL be discarded, with no validN after reset release.
REQ-028 Reset release SHALL act on the first rising edge after rst_n=1; grants are possible in that cycle.

Configuration
REQ-029 Macro TILE_ROM_ARBITER_RR_EN: when defined, NORMAL uses round-robin (last-granted port loses ties, initial favour port 0 after reset) and the starvation counter/FORCE1 logic is absent. When undefined, REQ-017..REQ-020 apply.

Verification
REQ-030 Only req0=1, addr0=0x10..0x1F on consecutive cycles -> gnt0 every cycle, valid0 at cycles 3..18 with data0=ROM[0x10..0x1F] in order, and valid1 never asserted.
REQ-031 req0 and req1 held continuously, STARVE_MAX=7 -> gnt0 for 7 cycles, then gnt1 for 1 cycle, repeating period 8; each valid lands 3 cycles after its grant.
REQ-032 req1 alone with addr1=0xA5 -> gnt1 same cycle, rom_address=0xA5, and valid1=1 with data1=ROM[0xA5] 3 cycles later.
REQ-033 rst_n pulsed low for 1 cycle with 2 reads in flight -> no valid0/valid1 afterwards, all outputs 0, and counter restarts from 0.
REQ-034 With TILE_ROM_ARBITER_RR_EN defined and both requesting continuously -> grants alternate 0,1,0,1 starting with port 0 after reset.
